// File: rtl/seq_pkg.sv
// Shared constants for the serial frame transmitter and its sequence-detector bench.
//   DEFAULT_WIDTH : default maximum frame length in bits
//   ST_*          : FSM state encoding (IDLE, SHIFT, DONE)
package seq_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/seq_tx_bitcnt.sv
// Loadable down-counter of remaining frame bits with a terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val into the counter (wins over dec)
//   load_val   : number of bits still to send after the current one
//   dec        : count down by one (saturates at zero)
//   last_c     : counter is zero, the bit currently on the line is the last one
module seq_tx_bitcnt #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last_c
);

   logic [CNT_W-1:0] count;

   // Remaining-bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !last_c) begin
         count <= count - CNT_W'(1);
      end
   end

   assign last_c = (count == '0);

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: accepts a frame of up to WIDTH bits, shifts it out
// MSB of the len-bit field first, then reports the number of sent bits equal
// to the bit sent just before them in the same frame.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_valid   : frame request
//   load_ready   : high only in IDLE
//   load_data    : frame bits, bit (len-1) goes out first
//   load_len     : bits to send; 0 or >WIDTH means WIDTH
//   serial_out   : serial bit, 0 when serial_valid is low
//   serial_valid : serial_out carries a frame bit
//   busy         : frame accepted and DONE not yet left
//   done         : one-cycle pulse after the last bit
//   pair_cnt     : equal-neighbour count, final while done is high
module seq_tx
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [WIDTH-1:0]           load_data,
   input  logic [$clog2(WIDTH+1)-1:0] load_len,
   output logic                       serial_out,
   output logic                       serial_valid,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(WIDTH)-1:0]   pair_cnt
);

   localparam int unsigned LEN_W = $clog2(WIDTH + 1);
   localparam int unsigned PC_W  = $clog2(WIDTH);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [WIDTH-1:0] aligned;
   logic [LEN_W-1:0] eff_len;
   logic [PC_W-1:0]  pair_nxt;
   logic             sout_nxt;
   logic             svalid_nxt;
   logic             done_nxt;
   logic             cnt_load;
   logic             cnt_dec;
   logic             last_c;

   // Effective length and left-justified frame, so the first bit sits at the MSB
   always_comb begin
      if ((load_len == '0) || (load_len > LEN_W'(WIDTH))) begin
         eff_len = LEN_W'(WIDTH);
      end else begin
         eff_len = load_len;
      end
      aligned = load_data << (LEN_W'(WIDTH) - eff_len);
   end

   seq_tx_bitcnt #(
      .CNT_W (LEN_W)
   ) u_bitcnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (eff_len - LEN_W'(1)),
      .dec      (cnt_dec),
      .last_c   (last_c)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         shreg        <= '0;
         serial_out   <= 1'b0;
         serial_valid <= 1'b0;
         done         <= 1'b0;
         busy         <= 1'b0;
         load_ready   <= 1'b1;
         pair_cnt     <= '0;
      end else begin
         state        <= state_nxt;
         shreg        <= shreg_nxt;
         serial_out   <= sout_nxt;
         serial_valid <= svalid_nxt;
         done         <= done_nxt;
         busy         <= (state_nxt != ST_IDLE);
         load_ready   <= (state_nxt == ST_IDLE);
         pair_cnt     <= pair_nxt;
      end
   end

   // Next state and next output values
   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      sout_nxt   = 1'b0;
      svalid_nxt = 1'b0;
      done_nxt   = 1'b0;
      pair_nxt   = pair_cnt;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (load_valid && load_ready) begin
               // First bit goes out on cycle 1; it has no predecessor.
               state_nxt  = ST_SHIFT;
               sout_nxt   = aligned[WIDTH-1];
               svalid_nxt = 1'b1;
               shreg_nxt  = {aligned[WIDTH-2:0], 1'b0};
               pair_nxt   = '0;
               cnt_load   = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (last_c) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
               shreg_nxt = '0;
            end else begin
               // serial_out still holds the previously sent bit here.
               sout_nxt   = shreg[WIDTH-1];
               svalid_nxt = 1'b1;
               shreg_nxt  = {shreg[WIDTH-2:0], 1'b0};
               cnt_dec    = 1'b1;
               if (shreg[WIDTH-1] == serial_out) begin
                  pair_nxt = pair_cnt + PC_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            shreg_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_tx.sv
// Directed self-checking bench for seq_tx (WIDTH=8).
module tb_seq_tx;

   logic       clk;
   logic       rst_n;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_data;
   logic [3:0] load_len;
   logic       serial_out;
   logic       serial_valid;
   logic       busy;
   logic       done;
   logic [2:0] pair_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   // Two-equal-consecutive-bit detector fed by the serial stream
   logic det_prev;
   logic det_prev_valid;
   int   det_hits;

   seq_tx #(
      .WIDTH (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .load_len     (load_len),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .busy         (busy),
      .done         (done),
      .pair_cnt     (pair_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      det_prev       = 1'b0;
      det_prev_valid = 1'b0;
      det_hits       = 0;
   end

   always @(negedge clk) begin
      if (serial_valid === 1'b1) begin
         if (det_prev_valid && (serial_out === det_prev)) det_hits = det_hits + 1;
         det_prev       = serial_out;
         det_prev_valid = 1'b1;
      end else begin
         det_prev_valid = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends one frame, scrambling load_data/load_len mid-frame, and reports what was seen.
   task automatic run_frame(input logic [7:0] d, input logic [3:0] len,
                            output logic [15:0] bits, output int nbits,
                            output int done_cyc, output logic [2:0] pc, output int bad);
      bits = '0; nbits = 0; done_cyc = -1; pc = '0; bad = 0;
      for (int i = 0; i < 10 && load_ready !== 1'b1; i++) tick();
      load_data  = d;
      load_len   = len;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done === 1'b1) begin
            done_cyc = c;
            pc       = pair_cnt;
            if (serial_valid !== 1'b0 || serial_out !== 1'b0 || busy !== 1'b1) bad++;
            break;
         end
         if (serial_valid === 1'b1) begin
            bits  = {bits[14:0], serial_out};
            nbits = nbits + 1;
         end else begin
            bad++;
         end
         if (busy !== 1'b1 || load_ready !== 1'b0) bad++;
         load_data = 8'($urandom);
         load_len  = 4'($urandom);
         tick();
      end
      if (done_cyc > 0) begin
         tick();
         if (done !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) bad++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_len = '0;
      tick(); tick();
      n_chk++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready got=%b want=1", load_ready); else n_pass++;
      n_chk++; if ({serial_out, serial_valid, busy, done} !== 4'b0000)
         $display("FAIL reset_outputs got=%b want=0000", {serial_out, serial_valid, busy, done}); else n_pass++;
      n_chk++; if (pair_cnt !== 3'd0) $display("FAIL reset_pair_cnt got=%0d want=0", pair_cnt); else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic check_frame(input string name, input logic [7:0] d, input logic [3:0] len,
                              input logic [15:0] xbits, input int xn, input logic [2:0] xpc);
      logic [15:0] bits; int nb; int dc; logic [2:0] pc; int bad;
      run_frame(d, len, bits, nb, dc, pc, bad);
      n_chk++; if (nb !== xn) $display("FAIL %s_nbits got=%0d want=%0d", name, nb, xn); else n_pass++;
      n_chk++; if (bits !== xbits) $display("FAIL %s_bits got=%h want=%h", name, bits, xbits); else n_pass++;
      n_chk++; if (dc !== xn + 1) $display("FAIL %s_done_cycle got=%0d want=%0d", name, dc, xn + 1); else n_pass++;
      n_chk++; if (pc !== xpc) $display("FAIL %s_pair_cnt got=%0d want=%0d", name, pc, xpc); else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL %s_protocol got=%0d errors want=0", name, bad); else n_pass++;
   endtask

   task automatic test_basic();
      check_frame("basic8", 8'b1011_0010, 4'd8, 16'h00B2, 8, 3'd2);
   endtask

   task automatic test_short();
      check_frame("len3", 8'hA7, 4'd3, 16'h0007, 3, 3'd2);
   endtask

   task automatic test_len_clamp();
      check_frame("len0", 8'hFF, 4'd0, 16'h00FF, 8, 3'd7);
      check_frame("len12", 8'hFF, 4'd12, 16'h00FF, 8, 3'd7);
   endtask

   task automatic test_len1();
      check_frame("len1", 8'h01, 4'd1, 16'h0001, 1, 3'd0);
   endtask

   task automatic test_back_to_back();
      int rdy_bad = 0; int a_done = -1; int b_start = -1; int b_done = -1;
      logic b_bit = 1'b0; logic [2:0] pc_a = '0; logic [2:0] pc_b = '0;
      for (int i = 0; i < 10 && load_ready !== 1'b1; i++) tick();
      load_data = 8'hC3; load_len = 4'd4; load_valid = 1'b1;
      tick();
      load_data = 8'h5A; load_len = 4'd8;
      for (int c = 1; c <= 40; c++) begin
         if (c <= 5 && load_ready !== 1'b0) rdy_bad++;
         if (done === 1'b1 && a_done < 0) begin a_done = c; pc_a = pair_cnt; end
         else if (done === 1'b1 && b_start > 0) begin b_done = c; pc_b = pair_cnt; break; end
         if (serial_valid === 1'b1 && a_done > 0 && b_start < 0) begin
            b_start = c; b_bit = serial_out; load_valid = 1'b0;
         end
         tick();
      end
      load_valid = 1'b0;
      n_chk++; if (rdy_bad !== 0) $display("FAIL b2b_ready_low got=%0d high cycles want=0", rdy_bad); else n_pass++;
      n_chk++; if (a_done !== 5) $display("FAIL b2b_a_done got=%0d want=5", a_done); else n_pass++;
      n_chk++; if (pc_a !== 3'd2) $display("FAIL b2b_a_pair_cnt got=%0d want=2", pc_a); else n_pass++;
      n_chk++; if (b_start !== 7) $display("FAIL b2b_b_start got=%0d want=7", b_start); else n_pass++;
      n_chk++; if (b_bit !== 1'b0) $display("FAIL b2b_b_first_bit got=%b want=0", b_bit); else n_pass++;
      n_chk++; if (b_done !== 15) $display("FAIL b2b_b_done got=%0d want=15", b_done); else n_pass++;
      n_chk++; if (pc_b !== 3'd1) $display("FAIL b2b_b_pair_cnt got=%0d want=1", pc_b); else n_pass++;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      int done_seen = 0;
      for (int i = 0; i < 10 && load_ready !== 1'b1; i++) tick();
      load_data = 8'b1011_0010; load_len = 4'd8; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      tick(); tick(); tick();
      n_chk++; if (pair_cnt !== 3'd1) $display("FAIL rstmid_pre_pair_cnt got=%0d want=1", pair_cnt); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++; if ({serial_out, serial_valid, busy, done, load_ready} !== 5'b00001)
         $display("FAIL rstmid_outputs got=%b want=00001", {serial_out, serial_valid, busy, done, load_ready}); else n_pass++;
      n_chk++; if (pair_cnt !== 3'd0) $display("FAIL rstmid_pair_cnt got=%0d want=0", pair_cnt); else n_pass++;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (done === 1'b1 || serial_valid === 1'b1) done_seen++;
         tick();
      end
      n_chk++; if (done_seen !== 0) $display("FAIL rstmid_no_done got=%0d active cycles want=0", done_seen); else n_pass++;
      check_frame("rstmid_next", 8'b1011_0010, 4'd8, 16'h00B2, 8, 3'd2);
   endtask

   task automatic test_detector();
      logic [15:0] bits; int nb; int dc; logic [2:0] pc; int bad; int h0;
      h0 = det_hits;
      run_frame(8'b0011_0011, 4'd8, bits, nb, dc, pc, bad);
      n_chk++; if (det_hits - h0 !== 4) $display("FAIL det_33_hits got=%0d want=4", det_hits - h0); else n_pass++;
      n_chk++; if (pc !== 3'(det_hits - h0)) $display("FAIL det_33_pair_cnt got=%0d want=%0d", pc, det_hits - h0); else n_pass++;
      h0 = det_hits;
      run_frame(8'b0101_0101, 4'd8, bits, nb, dc, pc, bad);
      n_chk++; if (det_hits - h0 !== 0) $display("FAIL det_55_hits got=%0d want=0", det_hits - h0); else n_pass++;
      n_chk++; if (pc !== 3'(det_hits - h0)) $display("FAIL det_55_pair_cnt got=%0d want=%0d", pc, det_hits - h0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_len_clamp();
      test_len1();
      test_back_to_back();
      test_reset_mid();
      test_detector();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 SHALL have parameter: WIDTH, 8, maximum frame length in bits (2..16).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: load_valid  input  1  frame request from producer.
REQ-005 SHALL have port: load_ready  output  1  block can accept a frame (high only in IDLE).
REQ-006 SHALL have port: load_data  input  WIDTH  frame bits; bit (len-1) is sent first.
REQ-007 SHALL have port: load_len  input  clog2(WIDTH+1)  number of bits to send.
REQ-008 SHALL have port: serial_out  output  1  serial bit stream feeding the sequence detector input.
REQ-009 SHALL have port: serial_valid  output  1  serial_out carries a frame bit this cycle.
REQ-010 SHALL have port: busy  output  1  frame in progress (LOAD accepted, DONE not yet left).
REQ-011 SHALL have port: done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL have port: pair_cnt  output  clog2(WIDTH)  count of sent bits equal to the preceding sent bit in the frame; valid while done=1.

Function
REQ-013 SHALL implement states IDLE, SHIFT, DONE; IDLE->SHIFT on load_valid&&load_ready, SHIFT->DONE after last bit, DONE->IDLE unconditionally.
REQ-014 SHALL capture load_data and effective length on the accepting edge (cycle 0).
REQ-015 SHALL treat load_len=0 or load_len>WIDTH as effective length WIDTH.
REQ-016 SHALL drive serial_valid=1 and one frame bit per cycle on cycles 1..len, MSB of the len-bit field first, all outputs registered.
REQ-017 SHALL drive serial_out=0 whenever serial_valid=0.
REQ-018 SHALL assert done=1 for exactly cycle len+1 (DONE state), with pair_cnt final and stable that cycle.
REQ-019 SHALL assert load_ready=1 again from cycle len+2; back-to-back frames therefore have a 2-cycle gap of serial_valid=0.
REQ-020 SHALL ignore load_valid while not in IDLE; load_data/load_len changes mid-frame SHALL have no effect.
REQ-021 SHALL clear pair_cnt at frame acceptance; first bit of a frame never increments it; comparison never crosses frames.
REQ-022 SHALL keep busy=1 from cycle 1 through cycle len+1 inclusive.
REQ-023 SHALL send a 1-bit frame (len=1) as one serial_valid cycle, done at cycle 2, pair_cnt=0.

Reset
REQ-024 SHALL, on rst_n=0 at any time, immediately force state IDLE, load_ready=1, serial_out=0, serial_valid=0, busy=0, done=0, pair_cnt=0, internal shift/count registers 0.
REQ-025 SHALL abandon an in-progress frame on reset with no done pulse; first acceptance possible on first rising edge with rst_n=1.

Structure
REQ-026 SHALL place the state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and default WIDTH constant in shared package seq_pkg, also used by the detector bench.
REQ-027 SHALL use one sub-module seq_tx_bitcnt: loadable down-counter of remaining bits with terminal-count flag.
REQ-028 SHALL fit in 120-400 lines of RTL, no memories, single clock domain.

Verification
REQ-029 SHALL check: load_data=8'b1011_0010, load_len=8 -> serial_out 1,0,1,1,0,0,1,0 on cycles 1..8, done at cycle 9, pair_cnt=2.
REQ-030 SHALL check: load_data=8'hxx with low 3 bits 3'b111, load_len=3 -> serial_out 1,1,1, done cycle 4, pair_cnt=2.
REQ-031 SHALL check: load_len=0, load_data=8'hFF -> 8 ones sent, pair_cnt=7; load_len=12 behaves identically.
REQ-032 SHALL check: load_valid held high continuously with two frames -> second frame first bit at cycle len+3, load_ready low throughout first frame.
REQ-033 SHALL check: rst_n pulsed low at cycle 4 of an 8-bit frame -> all outputs at reset values same cycle, no done, next frame sent correctly.
REQ-034 SHALL check: serial_out fed into the existing two-equal-bit detector -> detector high-output count equals pair_cnt for frames 8'b0011_0011 (pair_cnt=4) and 8'b0101_0101 (pair_cnt=0).
